// File: rtl/sparse_seq_pkg.sv
// sparse_seq_pkg: shared types and defaults for sparse_entry_sequencer.
//   state_t         - sequencer FSM states
//   ENTRY_W         - width of entry index / entry count
//   *_DEF           - default parameter values used by the sequencer and watchdog
package sparse_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam int ENTRY_W             = 6;
  localparam int SPARSE_ADDR_W_DEF   = 10;
  localparam int MEM_SPARSE_SIZE_DEF = 50;
  localparam int SPARSE_BASE_DEF     = 0;
  localparam int DUMMY_ADDR_DEF      = 1023;
  localparam int ACK_TIMEOUT_DEF     = 4;

endpackage

// File: rtl/sparse_entry_sequencer_ack_watchdog.sv
// ack_watchdog: counts WAIT_ACK cycles without a controller ack.
//   clk, rst_n   - clock, async active-low reset
//   i_clr        - zero the counter (issued with each start pulse)
//   i_en         - count one more unacknowledged cycle
//   o_expired    - the current cycle is the ACK_TIMEOUT-th unacknowledged one
module ack_watchdog
  import sparse_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Expired is flagged while the last permitted cycle is in progress, so the
  // FSM leaves after exactly ACK_TIMEOUT cycles without an ack.
  assign o_expired = (r_cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_en && !o_expired)  r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/sparse_entry_sequencer.sv
// sparse_entry_sequencer: walks the sparse-position memory one word at a
// time, issuing one start pulse to the accumulate controller per word and
// waiting for its busy handshake before advancing.
// Optional feature macro: DUMMY_INSERT_EN pads every run to MEM_SPARSE_SIZE
// entries; padding entries read DUMMY_ADDR and raise dummy_o.
//   clk, rst_n          - clock, async active-low reset
//   start_i             - run request (IDLE only), num_entries_i sampled with it
//   sparse_mem_addr_o   - sparse memory read address
//   ctrl_start_o        - one-cycle start pulse to the controller
//   ctrl_busy_i         - controller busy level
//   dummy_o             - current entry is a padding entry
//   entry_idx_o         - entry index in flight
//   busy_o              - run in progress
//   done_o              - one-cycle pulse at successful run end
//   error_o             - ack timeout, sticky until the next accepted start
module sparse_entry_sequencer
  import sparse_seq_pkg::*;
#(
  parameter int SPARSE_ADDR_W   = SPARSE_ADDR_W_DEF,
  parameter int MEM_SPARSE_SIZE = MEM_SPARSE_SIZE_DEF,
  parameter int SPARSE_BASE     = SPARSE_BASE_DEF,
  parameter int DUMMY_ADDR      = DUMMY_ADDR_DEF,
  parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ENTRY_W-1:0]       num_entries_i,
  output logic [SPARSE_ADDR_W-1:0] sparse_mem_addr_o,
  output logic                     ctrl_start_o,
  input  logic                     ctrl_busy_i,
  output logic                     dummy_o,
  output logic [ENTRY_W-1:0]       entry_idx_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o
);

  localparam logic [ENTRY_W-1:0] LP_MAX = ENTRY_W'(MEM_SPARSE_SIZE);

  state_t                   r_state, w_nxt_state;
  logic [SPARSE_ADDR_W-1:0] r_addr, w_nxt_addr;
  logic [ENTRY_W-1:0]       r_idx, w_nxt_idx;
  logic [ENTRY_W-1:0]       r_total, w_nxt_total;
  logic                     r_dummy, w_nxt_dummy;
  logic                     r_start, w_nxt_start;
  logic                     r_busy, w_nxt_busy;
  logic                     r_done, w_nxt_done;
  logic                     r_err, w_nxt_err;
  logic                     w_wd_clr, w_wd_en, w_wd_expired;

  // Entry being prepared: entry 0 when a run is accepted, otherwise idx+1.
  logic [ENTRY_W-1:0]       w_sel_idx;
  logic [ENTRY_W-1:0]       w_start_total;
  logic [SPARSE_ADDR_W-1:0] w_sel_addr;
  logic                     w_sel_dummy;

  assign w_sel_idx = (r_state == S_IDLE) ? '0 : (r_idx + ENTRY_W'(1));

`ifdef DUMMY_INSERT_EN
  logic [ENTRY_W-1:0] r_num, w_nxt_num;
  logic [ENTRY_W-1:0] w_sel_num;

  // The real-entry count is live on the input only in the accepting cycle.
  assign w_sel_num     = (r_state == S_IDLE) ? num_entries_i : r_num;
  assign w_start_total = LP_MAX;
  assign w_sel_dummy   = (w_sel_idx >= w_sel_num);
  assign w_nxt_num     = (r_state == S_IDLE && start_i) ? num_entries_i : r_num;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_num <= '0;
    else        r_num <= w_nxt_num;
  end
`else
  assign w_start_total = (num_entries_i > LP_MAX) ? LP_MAX : num_entries_i;
  assign w_sel_dummy   = 1'b0;
`endif

  // Address arithmetic wraps modulo 2^SPARSE_ADDR_W.
  assign w_sel_addr = w_sel_dummy ? SPARSE_ADDR_W'(DUMMY_ADDR)
                                  : (SPARSE_ADDR_W'(SPARSE_BASE) + SPARSE_ADDR_W'(w_sel_idx));

  ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wd (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  // Outputs are registered: values chosen in a state appear the next cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr;
    w_nxt_idx   = r_idx;
    w_nxt_total = r_total;
    w_nxt_dummy = r_dummy;
    w_nxt_busy  = r_busy;
    w_nxt_err   = r_err;
    w_nxt_start = 1'b0;
    w_nxt_done  = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_nxt_total = w_start_total;
          w_nxt_idx   = '0;
          w_nxt_busy  = 1'b1;
          w_nxt_err   = 1'b0;
          if (w_start_total == '0) begin
            w_nxt_state = S_FINISH;
          end else begin
            w_nxt_addr  = w_sel_addr;
            w_nxt_dummy = w_sel_dummy;
            w_nxt_state = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_nxt_start = 1'b1;
        w_wd_clr    = 1'b1;
        w_nxt_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A busy level already present counts as the ack.
        if (ctrl_busy_i)       w_nxt_state = S_WAIT_DONE;
        else if (w_wd_expired) w_nxt_state = S_ERROR;
        else                   w_wd_en     = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!ctrl_busy_i) w_nxt_state = S_NEXT;
      end
      S_NEXT: begin
        if ((r_idx + ENTRY_W'(1)) == r_total) begin
          w_nxt_state = S_FINISH;
        end else begin
          w_nxt_idx   = w_sel_idx;
          w_nxt_addr  = w_sel_addr;
          w_nxt_dummy = w_sel_dummy;
          w_nxt_state = S_ISSUE;
        end
      end
      S_FINISH: begin
        w_nxt_done  = 1'b1;
        w_nxt_busy  = 1'b0;
        w_nxt_dummy = 1'b0;
        w_nxt_state = S_IDLE;
      end
      S_ERROR: begin
        w_nxt_err   = 1'b1;
        w_nxt_busy  = 1'b0;
        w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_idx   <= '0;
      r_total <= '0;
      r_dummy <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_addr  <= w_nxt_addr;
      r_idx   <= w_nxt_idx;
      r_total <= w_nxt_total;
      r_dummy <= w_nxt_dummy;
      r_start <= w_nxt_start;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
    end
  end

  assign sparse_mem_addr_o = r_addr;
  assign ctrl_start_o      = r_start;
  assign dummy_o           = r_dummy;
  assign entry_idx_o       = r_idx;
  assign busy_o            = r_busy;
  assign done_o            = r_done;
  assign error_o           = r_err;

endmodule

// File: tb/tb_sparse_entry_sequencer.sv
module tb_sparse_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [5:0] num_entries_i = '0;
  logic       ctrl_busy_i = 1'b0;
  logic [9:0] sparse_mem_addr_o;
  logic       ctrl_start_o, dummy_o, busy_o, done_o, error_o;
  logic [5:0] entry_idx_o;

  sparse_entry_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_i           (start_i),
    .num_entries_i     (num_entries_i),
    .sparse_mem_addr_o (sparse_mem_addr_o),
    .ctrl_start_o      (ctrl_start_o),
    .ctrl_busy_i       (ctrl_busy_i),
    .dummy_o           (dummy_o),
    .entry_idx_o       (entry_idx_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor + controller model, both on the falling edge.
  int         n_start = 0, n_done = 0, n_double = 0;
  logic [9:0] addr_log [64];
  logic       dummy_log [64];
  logic [5:0] idx_log [64];
  logic       prev_start = 1'b0;
  int         bcnt = 0;
  bit         model_en = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ctrl_start_o) begin
        if (n_start < 64) begin
          addr_log[n_start]  = sparse_mem_addr_o;
          dummy_log[n_start] = dummy_o;
          idx_log[n_start]   = entry_idx_o;
        end
        if (prev_start) n_double++;
        n_start++;
      end
      if (done_o) n_done++;
    end
    prev_start = ctrl_start_o;
    if (!rst_n)                        bcnt = 0;
    else if (ctrl_start_o && model_en) bcnt = 9;
    else if (bcnt > 0)                 bcnt--;
    ctrl_busy_i = (bcnt > 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    n_start = 0; n_done = 0; n_double = 0;
  endtask

  // Returns at the negedge of cycle 1 (the ISSUE / FINISH-entry cycle).
  task automatic kick(input logic [5:0] n);
    @(negedge clk);
    start_i = 1'b1;
    num_entries_i = n;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Counts cycles from the start edge until done_o or error_o is seen.
  task automatic wait_end(output int cyc);
    cyc = 1;
    while (!done_o && !error_o && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("end_within_bound", (cyc < 3000), 1);
    repeat (5) @(negedge clk);
  endtask

  int lat;

  initial begin
    // Reset values
    #2;
    check("rst_addr",  sparse_mem_addr_o, 0);
    check("rst_start", ctrl_start_o, 0);
    check("rst_dummy", dummy_o, 0);
    check("rst_idx",   entry_idx_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_done",  done_o, 0);
    check("rst_error", error_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifndef DUMMY_INSERT_EN
    // Three real entries, 12 cycles each, done seen on cycle 38
    clear_logs();
    kick(6'd3);
    check("n3_busy_early", busy_o, 1);
    check("n3_addr_issue", sparse_mem_addr_o, 0);
    wait_end(lat);
    check("n3_latency", lat, 38);
    check("n3_starts", n_start, 3);
    check("n3_double", n_double, 0);
    check("n3_dones", n_done, 1);
    check("n3_error", error_o, 0);
    check("n3_busy_end", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      check("n3_addr",  addr_log[i], i);
      check("n3_dummy", dummy_log[i], 0);
      check("n3_idx",   idx_log[i], i);
    end

    // Zero entries: straight to FINISH, done two cycles after start
    clear_logs();
    kick(6'd0);
    wait_end(lat);
    check("n0_latency", lat, 2);
    check("n0_starts", n_start, 0);
    check("n0_dones", n_done, 1);

    // Clamp 60 -> 50 entries
    clear_logs();
    kick(6'd60);
    wait_end(lat);
    check("clamp_starts", n_start, 50);
    check("clamp_last_addr", addr_log[49], 49);
    check("clamp_latency", lat, 602);
    check("clamp_dones", n_done, 1);
`else
    // Two real entries padded to 50
    clear_logs();
    kick(6'd2);
    wait_end(lat);
    check("pad_starts", n_start, 50);
    check("pad_dones", n_done, 1);
    check("pad_latency", lat, 602);
    for (int i = 0; i < 50; i++) begin
      check("pad_addr",  addr_log[i], (i < 2) ? i : 1023);
      check("pad_dummy", dummy_log[i], (i < 2) ? 0 : 1);
    end
    check("pad_dummy_cleared", dummy_o, 0);

    // Zero entries: 50 dummies
    clear_logs();
    kick(6'd0);
    wait_end(lat);
    check("pad0_starts", n_start, 50);
    check("pad0_first_addr", addr_log[0], 1023);
    check("pad0_first_dummy", dummy_log[0], 1);
`endif

    // Controller never acks: error visible on cycle 7
    model_en = 1'b0;
    clear_logs();
    kick(6'd3);
    wait_end(lat);
    check("to_latency", lat, 7);
    check("to_error", error_o, 1);
    check("to_busy", busy_o, 0);
    check("to_dones", n_done, 0);
    check("to_starts", n_start, 1);
    model_en = 1'b1;
    clear_logs();
    kick(6'd1);
    check("to_error_cleared", error_o, 0);
    check("to_busy_restart", busy_o, 1);
    wait_end(lat);
    check("to_restart_dones", n_done, 1);
    check("to_restart_error", error_o, 0);

`ifndef DUMMY_INSERT_EN
    // start_i held during a run is ignored
    clear_logs();
    kick(6'd3);
    num_entries_i = 6'd5;
    start_i = 1'b1;
    repeat (30) @(negedge clk);
    start_i = 1'b0;
    lat = 31;
    while (!done_o && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check("ign_latency", lat, 38);
    repeat (5) @(negedge clk);
    check("ign_starts", n_start, 3);
    check("ign_dones", n_done, 1);
    check("ign_addr2", addr_log[2], 2);
`endif

    // Reset while in WAIT_DONE at idx 1
    clear_logs();
    kick(6'd3);
    lat = 1;
    while (!(entry_idx_o == 6'd1 && ctrl_busy_i && !ctrl_start_o) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("mid_reach_idx1", lat, 15);
    rst_n = 1'b0;
    #1;
    check("mid_addr",  sparse_mem_addr_o, 0);
    check("mid_idx",   entry_idx_o, 0);
    check("mid_busy",  busy_o, 0);
    check("mid_start", ctrl_start_o, 0);
    check("mid_dummy", dummy_o, 0);
    check("mid_done",  done_o, 0);
    check("mid_error", error_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    kick(6'd3);
    check("mid_restart_addr", sparse_mem_addr_o, 0);
    wait_end(lat);
    check("mid_restart_dones", n_done, 1);
    check("mid_restart_first", addr_log[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
